lsu_ctrl: RTL and testbench

//  Initiator side of the data-memory interface: accepts one load/store op from the CPU datapath,

---
 rtl/lsu_pkg.sv | 58 +++++
 rtl/lsu_lane.sv | 48 ++++
 rtl/lsu_ctrl.sv | 213 +++++++++++++++++++++
 tb/tb_lsu_ctrl.sv | 341 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: op codes, error codes, FSM states.
// Latency: n/a (declarations and pure helper functions only).
// Backpressure: n/a.
package lsu_pkg;

    // CPU-side op encoding carried on req_op
    typedef enum logic [2:0] {
        OP_LW  = 3'd0,
        OP_LB  = 3'd1,
        OP_LBU = 3'd2,
        OP_LH  = 3'd3,
        OP_LHU = 3'd4,
        OP_SW  = 3'd5,
        OP_SB  = 3'd6,
        OP_SH  = 3'd7
    } op_e;

    // Completion status carried on rsp_err
    localparam logic [1:0] ERR_OK      = 2'd0;
    localparam logic [1:0] ERR_ALIGN   = 2'd1;
    localparam logic [1:0] ERR_TIMEOUT = 2'd2;

    // Controller states; MRG only ever follows a sub-word store read
    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_RD   = 3'd1,
        ST_MRG  = 3'd2,
        ST_WR   = 3'd3,
        ST_RESP = 3'd4
    } state_e;

    // Word ops need a 4-byte boundary, half ops a 2-byte boundary, byte ops any address.
    function automatic logic op_misaligned(op_e op, logic [1:0] addr_lo);
        logic bad;
        case (op)
            OP_LW, OP_SW:          bad = (addr_lo != 2'b00);
            OP_LH, OP_LHU, OP_SH:  bad = addr_lo[0];
            default:               bad = 1'b0;
        endcase
        return bad;
    endfunction

    // Loads return memory data; every store ends with a write.
    function automatic logic op_is_load(op_e op);
        logic ld;
        case (op)
            OP_LW, OP_LB, OP_LBU, OP_LH, OP_LHU: ld = 1'b1;
            default:                             ld = 1'b0;
        endcase
        return ld;
    endfunction

    // Sub-word stores need the old word first (read-modify-write).
    function automatic logic op_is_rmw(op_e op);
        return (op == OP_SB) || (op == OP_SH);
    endfunction

endpackage

// File: rtl/lsu_lane.sv
// Lane steering for a 32-bit little-endian word: load extraction/extension and sub-word merge.
// Latency: purely combinational, zero cycles.
// Backpressure: none; outputs follow inputs.
module lsu_lane
    import lsu_pkg::*;
(
    input  logic [31:0] word,
    input  logic [31:0] wdata,
    input  logic [1:0]  lane,
    input  logic [2:0]  op,
    output logic [31:0] rdata,
    output logic [31:0] merged
);

    logic [7:0]  byte_v;
    logic [15:0] half_v;
    logic [31:0] byte_mask;
    logic [31:0] half_mask;
    logic [31:0] byte_ins;
    logic [31:0] half_ins;

    // Pick the addressed byte/half and extend it according to the load flavour
    always_comb begin
        byte_v = 8'(word >> {lane, 3'b000});
        half_v = 16'(word >> {lane[1], 4'b0000});
        case (op_e'(op))
            OP_LB:   rdata = {{24{byte_v[7]}}, byte_v};
            OP_LBU:  rdata = {24'h000000, byte_v};
            OP_LH:   rdata = {{16{half_v[15]}}, half_v};
            OP_LHU:  rdata = {16'h0000, half_v};
            default: rdata = word;
        endcase
    end

    // Overwrite only the addressed lane of the old word; full-word ops pass wdata through
    always_comb begin
        byte_mask = 32'h0000_00FF << {lane, 3'b000};
        half_mask = 32'h0000_FFFF << {lane[1], 4'b0000};
        byte_ins  = {24'h000000, wdata[7:0]} << {lane, 3'b000};
        half_ins  = {16'h0000, wdata[15:0]} << {lane[1], 4'b0000};
        case (op_e'(op))
            OP_SB:   merged = (word & ~byte_mask) | byte_ins;
            OP_SH:   merged = (word & ~half_mask) | half_ins;
            default: merged = wdata;
        endcase
    end

endmodule

// File: rtl/lsu_ctrl.sv
// Load/store controller: one op at a time to a word-wide memory, sub-word stores via read-modify-write.
// Latency: misaligned 1, SW 2, load L+2, SB/SH L+4 cycles (L = memory read latency, bounded by TIMEOUT).
// Backpressure: req_ready is high only while idle; the requester must take the one-cycle rsp pulse.
module lsu_ctrl
    import lsu_pkg::*;
#(
    parameter int ADDR_W  = 12,
    parameter int TIMEOUT = 15
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [2:0]        req_op,
    input  logic [31:0]       req_addr,
    input  logic [31:0]       req_wdata,
    output logic              rsp_valid,
    output logic [31:0]       rsp_rdata,
    output logic [1:0]        rsp_err,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_re,
    output logic              mem_we,
    output logic [31:0]       mem_wdata,
    input  logic              mem_rvalid,
    input  logic [31:0]       mem_rdata
);

    state_e            state;
    state_e            state_n;

    // Request fields captured on accept
    op_e               op_q;
    logic [1:0]        lane_q;
    logic [31:0]       wdata_q;
    // Old word captured for read-modify-write
    logic [31:0]       word_q;
    logic [7:0]        wait_cnt;

    logic              accept;
    logic              req_misaligned;
    logic              wait_expired;

    logic [31:0]       lane_word;
    logic [31:0]       lane_rdata;
    logic [31:0]       lane_merged;

    // Next values of the registered outputs
    logic              req_ready_d;
    logic              rsp_valid_d;
    logic [31:0]       rsp_rdata_d;
    logic [1:0]        rsp_err_d;
    logic [ADDR_W-1:0] mem_addr_d;
    logic              mem_re_d;
    logic              mem_we_d;
    logic [31:0]       mem_wdata_d;

    // Address bits above the memory window carry no meaning here
    logic              unused_addr_hi;
    assign unused_addr_hi = ^req_addr[31:ADDR_W];

    assign accept         = req_valid & req_ready;
    assign req_misaligned = op_misaligned(op_e'(req_op), req_addr[1:0]);
    assign wait_expired   = (wait_cnt == 8'(TIMEOUT));

    // Extraction works on the live read data; merging works on the word held from the read
    assign lane_word = (state == ST_MRG) ? word_q : mem_rdata;

    lsu_lane u_lane (
        .word   (lane_word),
        .wdata  (wdata_q),
        .lane   (lane_q),
        .op     (op_q),
        .rdata  (lane_rdata),
        .merged (lane_merged)
    );

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_n;
        end
    end

    // Next-state decision; a late rvalid outside RD is simply never looked at
    always_comb begin
        state_n = state;
        case (state)
            ST_IDLE: begin
                if (accept) begin
                    if (req_misaligned) begin
                        state_n = ST_RESP;
                    end else if (op_e'(req_op) == OP_SW) begin
                        state_n = ST_WR;
                    end else begin
                        state_n = ST_RD;
                    end
                end
            end
            ST_RD: begin
                if (mem_rvalid) begin
                    state_n = op_is_load(op_q) ? ST_RESP : ST_MRG;
                end else if (wait_expired) begin
                    state_n = ST_RESP;
                end
            end
            ST_MRG:  state_n = ST_WR;
            ST_WR:   state_n = ST_RESP;
            ST_RESP: state_n = ST_IDLE;
            default: state_n = ST_IDLE;
        endcase
    end

    // Output values for the coming cycle, derived from the transition being taken
    always_comb begin
        req_ready_d = (state_n == ST_IDLE);
        rsp_valid_d = (state_n == ST_RESP);
        mem_re_d    = (state == ST_IDLE) && (state_n == ST_RD);
        mem_we_d    = (state_n == ST_WR);
        rsp_rdata_d = rsp_rdata;
        rsp_err_d   = rsp_err;
        mem_addr_d  = mem_addr;
        mem_wdata_d = mem_wdata;
        case (state)
            ST_IDLE: begin
                if (accept) begin
                    mem_addr_d = {req_addr[ADDR_W-1:2], 2'b00};
                    if (req_misaligned) begin
                        rsp_err_d   = ERR_ALIGN;
                        rsp_rdata_d = 32'h0;
                    end else if (op_e'(req_op) == OP_SW) begin
                        mem_wdata_d = req_wdata;
                    end
                end
            end
            ST_RD: begin
                if (mem_rvalid) begin
                    if (op_is_load(op_q)) begin
                        rsp_err_d   = ERR_OK;
                        rsp_rdata_d = lane_rdata;
                    end
                end else if (wait_expired) begin
                    rsp_err_d   = ERR_TIMEOUT;
                    rsp_rdata_d = 32'h0;
                end
            end
            ST_MRG: begin
                mem_wdata_d = lane_merged;
            end
            ST_WR: begin
                rsp_err_d   = ERR_OK;
                rsp_rdata_d = 32'h0;
            end
            default: begin
            end
        endcase
    end

    // Output registers; reset also kills any pending memory pulse or response
    always_ff @(posedge clk) begin
        if (rst) begin
            req_ready <= 1'b1;
            rsp_valid <= 1'b0;
            rsp_rdata <= 32'h0;
            rsp_err   <= ERR_OK;
            mem_addr  <= '0;
            mem_re    <= 1'b0;
            mem_we    <= 1'b0;
            mem_wdata <= 32'h0;
        end else begin
            req_ready <= req_ready_d;
            rsp_valid <= rsp_valid_d;
            rsp_rdata <= rsp_rdata_d;
            rsp_err   <= rsp_err_d;
            mem_addr  <= mem_addr_d;
            mem_re    <= mem_re_d;
            mem_we    <= mem_we_d;
            mem_wdata <= mem_wdata_d;
        end
    end

    // Capture request fields on accept and the old word when a store read returns
    always_ff @(posedge clk) begin
        if (rst) begin
            op_q    <= OP_LW;
            lane_q  <= 2'b00;
            wdata_q <= 32'h0;
            word_q  <= 32'h0;
        end else begin
            if (accept) begin
                op_q    <= op_e'(req_op);
                lane_q  <= req_addr[1:0];
                wdata_q <= req_wdata;
            end
            if ((state == ST_RD) && mem_rvalid) begin
                word_q <= mem_rdata;
            end
        end
    end

    // Wait counter: zero in the first RD cycle, counts each RD cycle without rvalid
    always_ff @(posedge clk) begin
        if (rst) begin
            wait_cnt <= 8'd0;
        end else if (state != ST_RD) begin
            wait_cnt <= 8'd0;
        end else if (!mem_rvalid && !wait_expired) begin
            wait_cnt <= wait_cnt + 8'd1;
        end
    end

endmodule

// File: tb/tb_lsu_ctrl.sv
// Bench for lsu_ctrl: directed ops against a word memory model and a transaction-level expectation model.
// Latency: n/a.
// Backpressure: n/a.
module tb_lsu_ctrl;

    localparam int ADDR_W  = 12;
    localparam int TIMEOUT = 15;
    localparam int LW = 0, LB = 1, LBU = 2, LH = 3, LHU = 4, SW = 5, SB = 6, SH = 7;

    logic              clk = 1'b0;
    logic              rst;
    logic              req_valid;
    logic              req_ready;
    logic [2:0]        req_op;
    logic [31:0]       req_addr;
    logic [31:0]       req_wdata;
    logic              rsp_valid;
    logic [31:0]       rsp_rdata;
    logic [1:0]        rsp_err;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_re;
    logic              mem_we;
    logic [31:0]       mem_wdata;
    logic              mem_rvalid;
    logic [31:0]       mem_rdata;

    lsu_ctrl #(.ADDR_W(ADDR_W), .TIMEOUT(TIMEOUT)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_op     (req_op),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .rsp_valid  (rsp_valid),
        .rsp_rdata  (rsp_rdata),
        .rsp_err    (rsp_err),
        .mem_addr   (mem_addr),
        .mem_re     (mem_re),
        .mem_we     (mem_we),
        .mem_wdata  (mem_wdata),
        .mem_rvalid (mem_rvalid),
        .mem_rdata  (mem_rdata)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, want %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // ---------------- memory environment ----------------
    logic [31:0] mem     [0:1023];
    logic [31:0] ref_mem [0:1023];
    int          mem_lat  = 1;
    bit          mem_hold = 0;
    int          rd_due   = -1;
    int          late_at  = -1;
    logic [31:0] rd_word;

    always @(negedge clk) begin
        if (mem_we) mem[mem_addr[11:2]] = mem_wdata;
        if (mem_re && !mem_hold) begin
            rd_due  = cyc + mem_lat;
            rd_word = mem[mem_addr[11:2]];
        end
    end

    always @(posedge clk) begin
        #1;
        mem_rvalid = (cyc == rd_due) || (cyc == late_at);
        mem_rdata  = (cyc == rd_due) ? rd_word : $urandom;
    end

    // ---------------- expectation model ----------------
    function automatic bit m_misaligned(input int op, input int a);
        if (op == LW || op == SW) return (a % 4) != 0;
        if (op == LH || op == LHU || op == SH) return (a % 2) != 0;
        return 1'b0;
    endfunction

    function automatic logic [31:0] m_load(input int op, input logic [31:0] w, input int a);
        logic [7:0] b [4];
        int v;
        for (int k = 0; k < 4; k++) b[k] = w[8*k +: 8];
        case (op)
            LB:  begin v = int'(b[a]); if (v > 127) v -= 256; return 32'(v); end
            LBU: return 32'(int'(b[a]));
            LH:  begin v = int'(b[a]) + 256 * int'(b[a+1]); if (v > 32767) v -= 65536; return 32'(v); end
            LHU: return 32'(int'(b[a]) + 256 * int'(b[a+1]));
            default: return w;
        endcase
    endfunction

    function automatic logic [31:0] m_store(input int op, input logic [31:0] w, input logic [31:0] wd, input int a);
        logic [7:0] b [4];
        if (op == SW) return wd;
        for (int k = 0; k < 4; k++) b[k] = w[8*k +: 8];
        b[a] = wd[7:0];
        if (op == SH) b[a+1] = wd[15:8];
        return {b[3], b[2], b[1], b[0]};
    endfunction

    int          acc_at  = -1;
    int          busy_lo = -1;
    int          busy_hi = -1;
    int          re_at   = -1;
    int          we_at   = -1;
    int          rsp_at  = -1;
    logic [11:0] exp_addr;
    logic [31:0] exp_we_dat;
    logic [31:0] exp_rsp_dat;
    logic [1:0]  exp_err;
    bit          pend_valid;
    logic [9:0]  pend_idx;
    logic [31:0] pend_word;
    logic [31:0] last_rsp_dat;
    logic [1:0]  last_rsp_err;
    bit          checking = 0;

    // One compare point per cycle, half a period after the active edge
    always @(negedge clk) begin
        if (checking) begin
            check("req_ready", 32'(req_ready), 32'(!(cyc >= busy_lo && cyc <= busy_hi)));
            check("mem_re", 32'(mem_re), 32'(cyc == re_at));
            if (mem_re) check("mem_re_addr", 32'(mem_addr), 32'(exp_addr));
            check("mem_we", 32'(mem_we), 32'(cyc == we_at));
            if (mem_we) begin
                check("mem_we_addr", 32'(mem_addr), 32'(exp_addr));
                check("mem_wdata", mem_wdata, exp_we_dat);
            end
            check("rsp_valid", 32'(rsp_valid), 32'(cyc == rsp_at));
            if (rsp_valid) begin
                check("rsp_rdata", rsp_rdata, exp_rsp_dat);
                check("rsp_err", 32'(rsp_err), 32'(exp_err));
                last_rsp_dat = rsp_rdata;
                last_rsp_err = rsp_err;
            end
        end
    end

    task automatic preload(input logic [11:0] addr, input logic [31:0] w);
        mem[addr[11:2]]     = w;
        ref_mem[addr[11:2]] = w;
    endtask

    // Predict the whole transaction, then present the request for one accept edge (plus keep extra cycles)
    task automatic start_op(input int op, input logic [11:0] addr, input logic [31:0] wd,
                            input int lat, input bit hold, input int keep);
        int a;
        logic [31:0] cur;
        a            = int'(addr[1:0]);
        cur          = ref_mem[addr[11:2]];
        mem_lat      = lat;
        mem_hold     = hold;
        acc_at       = cyc + 1;
        exp_addr     = {addr[11:2], 2'b00};
        re_at        = -1;
        we_at        = -1;
        pend_valid   = 0;
        last_rsp_dat = 32'h5A5A_5A5A;
        last_rsp_err = 2'b11;
        exp_rsp_dat  = 32'h0;
        exp_err      = 2'd0;
        if (m_misaligned(op, a)) begin
            rsp_at  = acc_at;
            exp_err = 2'd1;
        end else if (op == SW) begin
            we_at      = acc_at;
            exp_we_dat = wd;
            rsp_at     = acc_at + 1;
            pend_valid = 1;
        end else begin
            re_at = acc_at;
            if (hold) begin
                rsp_at  = acc_at + TIMEOUT + 1;
                exp_err = 2'd2;
            end else if (op <= LHU) begin
                rsp_at      = acc_at + lat + 1;
                exp_rsp_dat = m_load(op, cur, a);
            end else begin
                we_at      = acc_at + lat + 2;
                rsp_at     = acc_at + lat + 3;
                exp_we_dat = m_store(op, cur, wd, a);
                pend_valid = 1;
            end
        end
        pend_idx  = addr[11:2];
        pend_word = exp_we_dat;
        busy_lo   = acc_at;
        busy_hi   = rsp_at;
        req_valid = 1'b1;
        req_op    = 3'(op);
        req_addr  = {20'hABCDE, addr};
        req_wdata = wd;
        @(negedge clk);
        for (int i = 0; i < keep; i++) begin
            req_op   = 3'(SW);
            req_addr = 32'h0;
            @(negedge clk);
        end
        req_valid = 1'b0;
        req_op    = 3'($urandom);
        req_addr  = $urandom;
        req_wdata = $urandom;
    endtask

    task automatic end_op();
        while (cyc <= busy_hi + 2) @(negedge clk);
        if (pend_valid) ref_mem[pend_idx] = pend_word;
        pend_valid = 0;
    endtask

    task automatic do_op(input int op, input logic [11:0] addr, input logic [31:0] wd, input int lat);
        start_op(op, addr, wd, lat, 1'b0, 0);
        end_op();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 1024; i++) begin
            mem[i]     = 32'h0;
            ref_mem[i] = 32'h0;
        end
        rst        = 1'b1;
        req_valid  = 1'b0;
        req_op     = 3'd0;
        req_addr   = 32'h0;
        req_wdata  = 32'h0;
        mem_rvalid = 1'b0;
        mem_rdata  = 32'h0;
        repeat (3) @(negedge clk);

        // Reset state
        check("rst_req_ready", 32'(req_ready), 32'd1);
        check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("rst_mem_re", 32'(mem_re), 32'd0);
        check("rst_mem_we", 32'(mem_we), 32'd0);
        check("rst_rsp_rdata", rsp_rdata, 32'h0);
        check("rst_rsp_err", 32'(rsp_err), 32'd0);
        check("rst_mem_addr", 32'(mem_addr), 32'h0);
        check("rst_mem_wdata", mem_wdata, 32'h0);
        rst = 1'b0;
        @(negedge clk);
        checking = 1;

        // Full-word store then read back
        do_op(SW, 12'h010, 32'hDEADBEEF, 1);
        check("sw_err", 32'(last_rsp_err), 32'd0);
        check("sw_mem", mem[4], 32'hDEADBEEF);
        do_op(LW, 12'h010, 32'h0, 2);
        check("lw_back", last_rsp_dat, 32'hDEADBEEF);

        // Sub-word loads and extension
        preload(12'h020, 32'h80FF7F01);
        do_op(LB, 12'h023, 32'h0, 1);
        check("lb_023", last_rsp_dat, 32'hFFFFFF80);
        do_op(LBU, 12'h023, 32'h0, 1);
        check("lbu_023", last_rsp_dat, 32'h00000080);
        do_op(LH, 12'h022, 32'h0, 1);
        check("lh_022", last_rsp_dat, 32'hFFFF80FF);
        do_op(LHU, 12'h020, 32'h0, 1);
        check("lhu_020", last_rsp_dat, 32'h00007F01);
        do_op(LB, 12'h021, 32'h0, 4);
        check("lb_021", last_rsp_dat, 32'h0000007F);
        // Requests offered while busy must be ignored
        start_op(LH, 12'h020, 32'h0, 3, 1'b0, 2);
        end_op();
        check("lh_020_busyreq", last_rsp_dat, 32'h00007F01);

        // Read-modify-write stores
        preload(12'h020, 32'h11223344);
        do_op(SB, 12'h021, 32'hFFFF_FFAA, 1);
        check("sb_021_mem", mem[8], 32'h1122AA44);
        check("sb_021_dat", last_rsp_dat, 32'h0);
        preload(12'h020, 32'h11223344);
        do_op(SH, 12'h022, 32'h1234BEEF, 2);
        check("sh_022_mem", mem[8], 32'hBEEF3344);
        do_op(SB, 12'h023, 32'h00000077, TIMEOUT);
        check("sb_023_maxlat", mem[8], 32'h77EF3344);

        // Misaligned ops: no memory traffic
        do_op(LW, 12'h006, 32'h0, 1);
        check("lw_006_err", 32'(last_rsp_err), 32'd1);
        do_op(SH, 12'h001, 32'hCAFE, 1);
        check("sh_001_err", 32'(last_rsp_err), 32'd1);
        do_op(SW, 12'h012, 32'h12345678, 1);
        do_op(LHU, 12'h003, 32'h0, 1);
        check("sw_kept", mem[4], 32'hDEADBEEF);

        // Timeouts, and a stray rvalid while idle
        start_op(LW, 12'h030, 32'h0, 1, 1'b1, 0);
        late_at = rsp_at + 2;
        end_op();
        check("lw_timeout_err", 32'(last_rsp_err), 32'd2);
        mem_hold = 0;
        preload(12'h034, 32'h0BADF00D);
        start_op(SB, 12'h035, 32'h11, 1, 1'b1, 0);
        end_op();
        check("sb_timeout_mem", mem[13], 32'h0BADF00D);
        do_op(LW, 12'h034, 32'h0, TIMEOUT);
        check("lw_maxlat", last_rsp_dat, 32'h0BADF00D);

        // Reset while an SB sits in the merge step
        preload(12'h040, 32'h11223344);
        start_op(SB, 12'h041, 32'h55, 1, 1'b0, 0);
        while (cyc < acc_at + 2) @(negedge clk);
        rst        = 1'b1;
        we_at      = -1;
        rsp_at     = -1;
        busy_hi    = acc_at + 2;
        pend_valid = 0;
        @(negedge clk);
        rst = 1'b0;
        check("abort_ready", 32'(req_ready), 32'd1);
        end_op();
        check("abort_mem", mem[16], 32'h11223344);
        do_op(LW, 12'h040, 32'h0, 1);
        check("post_abort_lw", last_rsp_dat, 32'h11223344);

        checking = 0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
